// File: rtl/playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : playback_ctrl
// Brief    : Streams 16-bit samples from SRAM to a DAC, one read per LRCK edge.
//            Optional PLAYBACK_LOOP_EN: wrap end_addr back to start_addr.
// Revision : 1.0 - initial release
// ============================================================================
module playback_ctrl #(
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              stop,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              daclrck,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_rd_req,
    input  logic              sram_rd_ack,
    input  logic [15:0]       sram_rd_data,
    output logic              dac_enable,
    output logic [15:0]       dac_data,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        READ      = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        sync_q;
    logic              lrck_edge;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [15:0]       dac_q, dac_d;
    logic              underrun_q, underrun_d;
    logic              stop_pend_q, stop_pend_d;
`ifdef PLAYBACK_LOOP_EN
    logic [ADDR_W-1:0] start_q, start_d;
`endif

    // Both LRCK transitions mark a new slot, so either direction counts.
    assign lrck_edge = sync_q[1] ^ sync_q[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= 3'b000;
            state_q     <= IDLE;
            addr_q      <= '0;
            end_q       <= '0;
            dac_q       <= 16'h0000;
            underrun_q  <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[1:0], daclrck};
            state_q     <= state_d;
            addr_q      <= addr_d;
            end_q       <= end_d;
            dac_q       <= dac_d;
            underrun_q  <= underrun_d;
            stop_pend_q <= stop_pend_d;
        end
    end

`ifdef PLAYBACK_LOOP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= '0;
        end else begin
            start_q <= start_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        end_d       = end_q;
        dac_d       = dac_q;
        underrun_d  = underrun_q;
        stop_pend_d = stop_pend_q;
`ifdef PLAYBACK_LOOP_EN
        start_d     = start_q;
`endif
        case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (play && !stop) begin
                    underrun_d = 1'b0;
                    end_d      = end_addr;
`ifdef PLAYBACK_LOOP_EN
                    start_d    = start_addr;
`endif
                    if (start_addr <= end_addr) begin
                        addr_d  = start_addr;
                        state_d = WAIT_EDGE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WAIT_EDGE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (lrck_edge) begin
                    state_d = READ;
                end
            end
            READ: begin
                // A slot edge with the read still pending is lost, not queued.
                if (lrck_edge) begin
                    underrun_d = 1'b1;
                end
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (sram_rd_ack) begin
                    dac_d       = sram_rd_data;
                    stop_pend_d = 1'b0;
                    if (stop_pend_q || stop) begin
                        state_d = IDLE;
                    end else if (addr_q == end_q) begin
`ifdef PLAYBACK_LOOP_EN
                        addr_d  = start_q;
                        state_d = WAIT_EDGE;
`else
                        state_d = DONE;
`endif
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = WAIT_EDGE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d == IDLE && state_q != IDLE) begin
            dac_d = 16'h0000;
        end
    end

    // Decoded straight from the state so reset drops the request asynchronously.
    assign sram_rd_req = (state_q == READ);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign dac_enable  = busy;
    assign sram_addr   = addr_q;
    assign dac_data    = dac_q;
    assign underrun    = underrun_q;

endmodule
`default_nettype wire

// File: doc/playback_ctrl.md
PLAYBACK_CTRL -- requirements
Module: playback_ctrl

Interface
REQ-001 Parameter ADDR_W, default 20, SHALL set the SRAM word-address width.
REQ-002 clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-003 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 play  input  1  single-cycle start request.
REQ-005 stop  input  1  single-cycle abort request.
REQ-006 start_addr  input  ADDR_W  first sample address, sampled when play is accepted.
REQ-007 end_addr  input  ADDR_W  last sample address (inclusive), sampled when play is accepted.
REQ-008 daclrck  input  1  codec LR clock, asynchronous to clk.
REQ-009 sram_addr  output  ADDR_W  read address to the SRAM arbiter.
REQ-010 sram_rd_req  output  1  read request; held high until acknowledged.
REQ-011 sram_rd_ack  input  1  one-cycle read acknowledge; sram_rd_data is valid in the same cycle.
REQ-012 sram_rd_data  input  16  read sample.
REQ-013 dac_enable  output  1  enables the DAC serializer.
REQ-014 dac_data  output  16  sample presented to the DAC serializer.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at the end of playback.
REQ-017 underrun  output  1  sticky flag; set when an LRCK edge arrives while a read is outstanding.

Function
REQ-018 daclrck SHALL pass through a 3-flop synchronizer; lrck_edge = ff2 XOR ff3, so both LRCK edges (left and right slots) are detected.
REQ-019 FSM states SHALL be IDLE, WAIT_EDGE, READ, DONE.
REQ-020 IDLE: play with start_addr <= end_addr -> load the address counter with start_addr, go to WAIT_EDGE; play with start_addr > end_addr -> go to DONE with no read issued.
REQ-021 WAIT_EDGE: lrck_edge -> go to READ; sram_rd_req and sram_addr SHALL be valid in the first READ cycle (one clk after lrck_edge).
REQ-022 READ: sram_rd_req stays high and sram_addr stays stable until sram_rd_ack; in the ack cycle, sram_rd_data is registered into dac_data, visible the next cycle.
REQ-023 After the ack: if address == end_addr, go to DONE; otherwise increment the address modulo 2^ADDR_W and go to WAIT_EDGE.
REQ-024 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-025 An lrck_edge during READ SHALL set underrun and SHALL NOT queue an extra read.
REQ-026 stop in WAIT_EDGE -> go to IDLE next cycle; stop in READ SHALL be latched, and the FSM goes to IDLE after the pending ack without a done pulse; stop in IDLE or DONE is ignored.
REQ-027 play while busy SHALL be ignored; play and stop in the same IDLE cycle: stop wins.
REQ-028 dac_enable SHALL equal busy; dac_data is cleared to 0 on entry to IDLE.
REQ-029 underrun is cleared only by reset or by an accepted play.

Reset
REQ-030 On reset: FSM = IDLE; sram_rd_req, dac_enable, busy, done, underrun = 0; sram_addr, dac_data = 0; synchronizer flops = 0.
REQ-031 Reset asserted mid-READ SHALL drop sram_rd_req immediately (asynchronously); an ack arriving during reset is ignored.

Configuration
REQ-032 With PLAYBACK_LOOP_EN defined, the ack of end_addr SHALL reload start_addr and return to WAIT_EDGE (no DONE, no done pulse); playback ends only on stop.
REQ-033 Without PLAYBACK_LOOP_EN, behaviour SHALL be exactly as REQ-023/REQ-024.

Verification
REQ-034 start=0x10, end=0x12, play, 3 LRCK edges, ack 2 clk after each req -> addresses 0x10, 0x11, 0x12 read in order; dac_data follows the samples; one done pulse; busy falls.
REQ-035 start=0x5, end=0x3, play -> no sram_rd_req; done pulses 1 cycle after play.
REQ-036 Ack withheld for longer than the LRCK half-period -> underrun=1, only one read issued for that edge; underrun stays set until the next play.
REQ-037 stop asserted in READ with ack arriving 4 clk later -> req held until ack, then IDLE, no done pulse, dac_data=0.
REQ-038 PLAYBACK_LOOP_EN, start=0x0, end=0x1, 5 edges -> read sequence 0, 1, 0, 1, 0; done never asserted.
REQ-039 rst asserted while sram_rd_req=1 -> req=0 in the same cycle; all outputs at their reset values.
